// File: rtl/sensor_board_scanner.sv
// sensor_board_scanner: scans the reed-switch matrix and publishes a
// debounced 32-bit board word for the memory manager (CPU addr 0x1001).
// Ports: clock, reset (async, active-low), enable, colSense[COLS] (active-low),
//        rowDrive[ROWS] (one-hot active-low), sensorBoardOut[32],
//        frameValid, boardChanged, scanBusy.
// Optional macro SENSOR_SCAN_IRQ_EN adds irqClear (in) and scanIrq (out).
module sensor_board_scanner #(
    parameter int ROWS           = 8,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 50,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [COLS-1:0] colSense,
`ifdef SENSOR_SCAN_IRQ_EN
    input  logic            irqClear,
    output logic            scanIrq,
`endif
    output logic [ROWS-1:0] rowDrive,
    output logic [31:0]     sensorBoardOut,
    output logic            frameValid,
    output logic            boardChanged,
    output logic            scanBusy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t          state, state_d;
    logic [RW-1:0]   row, row_d;
    logic [SW-1:0]   settle, settle_d;
    logic [DW-1:0]   stable, stable_d;
    logic [31:0]     cand, cand_d;
    logic [31:0]     prev, prev_d;
    logic [31:0]     board, board_d;
    logic [COLS-1:0] sync1, sync2;
    logic [COLS-1:0] sense;

    // Columns are asynchronous reed contacts; invert so present = 1.
    assign sense = ~sync2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            row    <= '0;
            settle <= '0;
            stable <= '0;
            cand   <= '0;
            prev   <= '0;
            board  <= '0;
            sync1  <= '1;
            sync2  <= '1;
        end else begin
            state  <= state_d;
            row    <= row_d;
            settle <= settle_d;
            stable <= stable_d;
            cand   <= cand_d;
            prev   <= prev_d;
            board  <= board_d;
            sync1  <= colSense;
            sync2  <= sync1;
        end
    end

    always_comb begin
        state_d      = state;
        row_d        = row;
        settle_d     = settle;
        stable_d     = stable;
        cand_d       = cand;
        prev_d       = prev;
        board_d      = board;
        rowDrive     = '1;
        frameValid   = 1'b0;
        boardChanged = 1'b0;
        unique case (state)
            IDLE: begin
                row_d    = '0;
                settle_d = '0;
                if (enable) state_d = DRIVE;
            end
            DRIVE: begin
                rowDrive[row] = 1'b0;
                settle_d      = settle + SW'(1);
                if (settle == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end
            end
            SAMPLE: begin
                rowDrive[row] = 1'b0;
                cand_d[int'(row)*COLS +: COLS] = sense;
                // A disabled scan abandons the frame; prev/stable untouched.
                if (!enable) begin
                    state_d = IDLE;
                end else if (row == LAST_ROW) begin
                    state_d = COMMIT;
                end else begin
                    row_d   = row + RW'(1);
                    state_d = DRIVE;
                end
            end
            COMMIT: begin
                frameValid = 1'b1;
                if (cand == prev)
                    stable_d = (stable == DB_MAX) ? stable : stable + DW'(1);
                else
                    stable_d = DW'(1);
                if (stable_d >= DB_MAX && cand != board) begin
                    board_d      = cand;
                    boardChanged = 1'b1;
                end
                prev_d   = cand;
                row_d    = '0;
                settle_d = '0;
                state_d  = enable ? DRIVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sensorBoardOut = board;
    assign scanBusy       = (state != IDLE);

`ifdef SENSOR_SCAN_IRQ_EN
    // Set has priority over a coincident clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            scanIrq <= 1'b0;
        else if (boardChanged)
            scanIrq <= 1'b1;
        else if (irqClear)
            scanIrq <= 1'b0;
    end
`endif

endmodule

// File: doc/sensor_board_scanner.md
Name: sensor_board_scanner

Overview:
- Scans the physical checkerboard reed-switch matrix and produces the debounced 32-bit sensor board word.
- Its output drives the sensor-board input of the memory manager, which the CPU reads at address 0x1001.
- It is the hardware producer for that memory-mapped register: it drives the row lines, samples the column lines, debounces whole frames and flags changes.

Parameters:
- ROWS, 8, number of matrix rows; ROWS*COLS must equal 32.
- COLS, 4, number of column sense lines (dark squares per row).
- SETTLE_CYCLES, 50, cycles a row is driven before sampling; minimum 3.
- DEBOUNCE_SCANS, 4, consecutive identical frames required before commit; minimum 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run continuous scanning while high
- colSense  in  COLS  raw column inputs, asynchronous, active-low (0 = piece present)
- rowDrive  out  ROWS  row select, one-hot active-low; all ones when idle
- sensorBoardOut  out  32  debounced board; bit row*COLS+col, 1 = piece present
- frameValid  out  1  one-cycle pulse at every completed frame
- boardChanged  out  1  one-cycle pulse when sensorBoardOut updates
- scanBusy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (reset low, async) puts the block in this state:
  - FSM = IDLE, rowDrive = all ones, sensorBoardOut = 0.
  - frameValid = 0, boardChanged = 0, scanBusy = 0.
  - Row index, settle counter, stable counter, candidate frame and previous frame all = 0.
- colSense passes through a 2-flop synchronizer and is inverted, so present = 1.
- FSM states are IDLE, DRIVE, SAMPLE, COMMIT.
- IDLE:
  - If enable is high, go to DRIVE next cycle with row = 0 and settle counter = 0.
- DRIVE:
  - rowDrive[row] = 0, all other bits 1.
  - The settle counter increments each cycle.
  - After SETTLE_CYCLES cycles, go to SAMPLE.
- SAMPLE (1 cycle, row still driven):
  - Write the synchronized sense bits into candidate bits [row*COLS +: COLS].
  - If row < ROWS-1: row++ and go to DRIVE.
  - Otherwise go to COMMIT.
- COMMIT (1 cycle, rowDrive = all ones):
  - Pulse frameValid.
  - Stable counter: if candidate == previous frame, increment it, saturating at DEBOUNCE_SCANS. Otherwise set it to 1.
  - If the counter value (after update) >= DEBOUNCE_SCANS and candidate != sensorBoardOut:
    - Register candidate into sensorBoardOut.
    - Pulse boardChanged in the same cycle as frameValid; sensorBoardOut shows the new value on the following cycle.
  - Set previous frame = candidate.
  - Next state: DRIVE row 0 if enable is high, else IDLE.
- Frame length = ROWS*(SETTLE_CYCLES+1)+1 cycles, which is 409 with the defaults.
- Enable dropped mid-frame:
  - The current row completes its SAMPLE.
  - The FSM then goes to IDLE instead of advancing to the next row.
  - The partial frame is discarded: previous frame and stable counter are unchanged, no pulses.
- Identical committed frames never re-pulse boardChanged.
- With DEBOUNCE_SCANS = 1, every frame that differs from sensorBoardOut commits.
- sensorBoardOut holds its value while IDLE; it is only cleared by reset.
- Reset asserted mid-frame aborts immediately and rowDrive returns to all ones asynchronously.

Optional Feature:
- Macro: SENSOR_SCAN_IRQ_EN.
- Defined:
  - Adds input irqClear (1) and output scanIrq (1).
  - scanIrq is set on boardChanged and stays high until irqClear is sampled high.
  - If set and clear happen in the same cycle, set wins.
  - scanIrq resets to 0.
- Undefined: both ports are absent and no irq logic is generated.

Test Plan:
- Reset, then enable = 1, colSense held all ones (empty board) → rowDrive walks 0xFE, 0xFD … 0x7F with 50 driven cycles + 1 sample per row; frameValid pulses every 409 cycles; sensorBoardOut stays 0x00000000 and boardChanged never pulses.
- Piece held at row 2, col 1 (colSense = 4'b1101 only while rowDrive[2] = 0) → after the 4th identical frame, boardChanged pulses once and sensorBoardOut = 0x00000200; the 5th and later frames give no boardChanged.
- Same square toggles every frame for 10 frames, then holds present → no commit during toggling; commit to 0x00000200 only on the 4th stable frame after toggling stops.
- enable dropped during row 5 DRIVE → row 5 SAMPLE completes, FSM goes to IDLE, rowDrive = 0xFF, scanBusy = 0, no frameValid; re-enable restarts at row 0 and the stable count is preserved.
- reset pulsed low mid-frame with sensorBoardOut = 0x00000200 → rowDrive = 0xFF, sensorBoardOut = 0 immediately; debounce restarts from zero.
- With SENSOR_SCAN_IRQ_EN defined → scanIrq rises with the first boardChanged, stays high across later frames, falls the cycle after irqClear = 1; irqClear coincident with a new boardChanged leaves scanIrq = 1.
